// File: rtl/calc_display_scan_if.sv
// Calculator-to-display bus: captured result fields in, scanned display pins out.
interface calc_display_scan_if;
  logic       load;
  logic [3:0] sign_code;
  logic [3:0] q;
  logic [1:0] sel;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output load, sign_code, q, sel,
    input  an, seg, dp
  );

  modport slave (
    input  load, sign_code, q, sel,
    output an, seg, dp
  );
endinterface

// File: rtl/calc_display_scan.sv
// Four-digit multiplexed common-anode driver with frame-aligned double buffering.
// Optional blinking of invalid fields is enabled by defining CALC_DISP_BLINK_EN.
module calc_display_scan #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic                clk,
  input  logic                rst_n,
  calc_display_scan_if.slave  bus
);

  localparam int DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_S     = 7'b0010010;
  localparam logic [6:0] SEG_N     = 7'b0101011;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  if (REFRESH_DIV < 2 || BLINK_FRAMES < 1) begin : g_bad_cfg
    $error("calc_display_scan: REFRESH_DIV must be >= 2 and BLINK_FRAMES >= 1");
  end

  typedef struct packed {
    logic [3:0] sign_code;
    logic [3:0] q;
    logic [1:0] sel;
  } result_t;

  function automatic logic [6:0] digit_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_E;
    endcase
    return s;
  endfunction

  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       idx_q, idx_d;
  result_t          shadow_q, shadow_d;
  result_t          disp_q, disp_d;
  logic             pending_q, pending_d;
  logic             valid_q, valid_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;

  logic tick;
  logic frame_bnd;
  logic fields_bad;
  logic blink_blank;

  assign tick      = (div_q == DIV_LAST);
  assign frame_bnd = tick && (idx_q == 2'd3);

  // Scan divider, shadow capture and frame-aligned swap into the display register.
  always_comb begin
    div_d     = tick ? '0 : div_q + 1'b1;
    idx_d     = tick ? idx_q + 2'd1 : idx_q;
    shadow_d  = shadow_q;
    disp_d    = disp_q;
    pending_d = pending_q;
    valid_d   = valid_q;
    if (frame_bnd && pending_q) begin
      disp_d    = shadow_q;
      valid_d   = 1'b1;
      pending_d = 1'b0;
    end
    // A load on the swap edge wins over the clear, so the new value waits a frame.
    if (bus.load) begin
      shadow_d.sign_code = bus.sign_code;
      shadow_d.q         = bus.q;
      shadow_d.sel       = bus.sel;
      pending_d          = 1'b1;
    end
  end

  assign fields_bad = (disp_q.q > 4'd9) ||
                      !((disp_q.sign_code == 4'b1111) || (disp_q.sign_code == 4'b1110));

`ifdef CALC_DISP_BLINK_EN
  localparam int FR_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FR_W-1:0] FR_LAST = FR_W'(BLINK_FRAMES - 1);

  logic [FR_W-1:0] frame_cnt_q, frame_cnt_d;
  logic            phase_q, phase_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    phase_d     = phase_q;
    if (frame_bnd) begin
      if (frame_cnt_q == FR_LAST) begin
        frame_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign blink_blank = phase_q && fields_bad;
`else
  assign blink_blank = 1'b0;
`endif

  for (genvar gi = 0; gi < 4; gi++) begin : g_an
    assign an_d[gi] = (idx_q != 2'(gi));
  end

  // Glyph for the digit currently selected; registered so outputs follow idx by one edge.
  always_comb begin
    seg_d = SEG_BLANK;
    case (idx_q)
      2'd3: begin
        case (disp_q.sel)
          2'b00:   seg_d = SEG_A;
          2'b01:   seg_d = SEG_S;
          2'b10:   seg_d = SEG_N;
          default: seg_d = SEG_D;
        endcase
      end
      2'd2: seg_d = SEG_BLANK;
      2'd1: begin
        if (disp_q.sign_code == 4'b1111)      seg_d = SEG_DASH;
        else if (disp_q.sign_code == 4'b1110) seg_d = SEG_BLANK;
        else                                  seg_d = SEG_E;
      end
      default: seg_d = digit_seg(disp_q.q);
    endcase
    if (blink_blank && !idx_q[1]) begin
      seg_d = SEG_BLANK;
    end
    if (!valid_q) begin
      seg_d = SEG_DASH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= '0;
      idx_q     <= 2'd0;
      shadow_q  <= '0;
      disp_q    <= '0;
      pending_q <= 1'b0;
      valid_q   <= 1'b0;
      an_q      <= 4'b1111;
      seg_q     <= SEG_BLANK;
    end else begin
      div_q     <= div_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      disp_q    <= disp_d;
      pending_q <= pending_d;
      valid_q   <= valid_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = 1'b1;

endmodule

// File: tb/tb_calc_display_scan.sv
// Directed bench for calc_display_scan with a per-cycle character-level display model.
module tb_calc_display_scan;
  localparam int RD = 4;
  localparam int BF = 2;
  localparam int FRAME = 4 * RD;
`ifdef CALC_DISP_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic chk_en = 1'b0;
  int tests = 0;
  int fails = 0;

  calc_display_scan_if bus();

  calc_display_scan #(.REFRESH_DIV(RD), .BLINK_FRAMES(BF)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Model state: edges since reset release, shadow/display contents, frames shown.
  int         ecount = 0;
  int         frames = 0;
  logic [3:0] sh_sign = 0, sh_q = 0, d_sign = 0, d_q = 0;
  logic [1:0] sh_sel = 0, d_sel = 0;
  logic       m_pending = 0, m_valid = 0;
  logic [3:0] exp_an = 4'b1111;
  logic [6:0] exp_seg = 7'b1111111;
  logic       exp_dp = 1'b1;

  function automatic byte char_at(input int pos);
    logic bad;
    bad = (d_q > 9) || !(d_sign == 4'hF || d_sign == 4'hE);
    if (!m_valid) return "-";
    if (BLINK && ((frames / BF) % 2 == 1) && bad && pos < 2) return " ";
    case (pos)
      3: begin
        case (d_sel)
          2'd0: return "A";
          2'd1: return "S";
          2'd2: return "n";
          default: return "d";
        endcase
      end
      2: return " ";
      1: return (d_sign == 4'hF) ? "-" : (d_sign == 4'hE) ? " " : "E";
      default: return (d_q < 10) ? byte'(8'h30 + d_q) : "E";
    endcase
  endfunction

  function automatic logic [6:0] font(input byte c);
    case (c)
      "0": return 7'b1000000;
      "1": return 7'b1111001;
      "2": return 7'b0100100;
      "3": return 7'b0110000;
      "4": return 7'b0011001;
      "5": return 7'b0010010;
      "6": return 7'b0000010;
      "7": return 7'b1111000;
      "8": return 7'b0000000;
      "9": return 7'b0010000;
      "A": return 7'b0001000;
      "S": return 7'b0010010;
      "n": return 7'b0101011;
      "d": return 7'b0100001;
      "E": return 7'b0000110;
      "-": return 7'b0111111;
      " ": return 7'b1111111;
      default: return 7'b1010101;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ecount    <= 0;
      frames    <= 0;
      m_pending <= 1'b0;
      m_valid   <= 1'b0;
      sh_sign <= 0; sh_q <= 0; sh_sel <= 0;
      d_sign  <= 0; d_q  <= 0; d_sel  <= 0;
      exp_an  <= 4'b1111;
      exp_seg <= 7'b1111111;
      exp_dp  <= 1'b1;
    end else begin
      exp_an  <= 4'b1111 ^ (4'b0001 << ((ecount / RD) % 4));
      exp_seg <= font(char_at((ecount / RD) % 4));
      exp_dp  <= 1'b1;
      if (ecount % FRAME == FRAME - 1) begin
        frames <= frames + 1;
        if (m_pending) begin
          d_sign <= sh_sign; d_q <= sh_q; d_sel <= sh_sel;
          m_valid   <= 1'b1;
          m_pending <= 1'b0;
        end
      end
      if (bus.load) begin
        sh_sign <= bus.sign_code; sh_q <= bus.q; sh_sel <= bus.sel;
        m_pending <= 1'b1;
      end
      ecount <= ecount + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      tests++;
      if ({bus.an, bus.seg, bus.dp} !== {exp_an, exp_seg, exp_dp}) begin
        fails++;
        $display("FAIL scan edge=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                 ecount, bus.an, bus.seg, bus.dp, exp_an, exp_seg, exp_dp);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s got %b want %b", name, act, expv);
    end else begin
      $display("[TB] ok %s = %b", name, act);
    end
  endtask

  task automatic drive(input logic ld, input logic [3:0] s, input logic [3:0] qq, input logic [1:0] m);
    bus.load = ld; bus.sign_code = s; bus.q = qq; bus.sel = m;
  endtask

  // Return at a negedge where the next rising edge has the given in-frame position.
  task automatic wait_slot(input int k);
    for (int i = 0; i < 3 * FRAME; i++) begin
      if (ecount % FRAME == k) return;
      @(negedge clk);
    end
    tests++; fails++;
    $display("FAIL wait_slot timeout slot=%0d", k);
  endtask

  task automatic check_digit(input string name, input int pos, input logic [6:0] segv);
    logic [3:0] want_an;
    want_an = 4'b1111 ^ (4'b0001 << pos);
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (bus.an == want_an) begin
        check(name, {25'd0, bus.seg}, {25'd0, segv});
        return;
      end
    end
    tests++; fails++;
    $display("FAIL %s timeout waiting for an=%b", name, want_an);
  endtask

  initial begin
    logic seen1, seen9;
    drive(1'b0, 4'h0, 4'h0, 2'd0);
    repeat (3) @(negedge clk);
    check("reset_an", {28'd0, bus.an}, 32'h0000000F);
    chk_en = 1'b1;
    rst_n  = 1'b1;
    @(negedge clk);
    check("first_edge_an", {28'd0, bus.an}, {28'd0, 4'b1110});
    check("first_edge_seg", {25'd0, bus.seg}, {25'd0, 7'b0111111});
    repeat (2 * FRAME) @(negedge clk);

    // Negative 7, subtract.
    drive(1'b1, 4'hF, 4'd7, 2'b01);
    @(negedge clk);
    drive(1'b0, 4'h0, 4'h0, 2'd0);
    repeat (20) @(negedge clk);
    check_digit("neg7_mode_S", 3, 7'b0010010);
    check_digit("neg7_blank2", 2, 7'b1111111);
    check_digit("neg7_sign", 1, 7'b0111111);
    check_digit("neg7_q", 0, 7'b1111000);

    // Invalid q, positive, multiply.
    drive(1'b1, 4'hE, 4'd12, 2'b10);
    @(negedge clk);
    drive(1'b0, 4'h0, 4'h0, 2'd0);
    repeat (20) @(negedge clk);
    check_digit("q12_mode_n", 3, 7'b0101011);
    if (!BLINK) begin
      check_digit("q12_sign_blank", 1, 7'b1111111);
      check_digit("q12_q_E", 0, 7'b0000110);
    end
    repeat (5 * FRAME) @(negedge clk);

    // q=5 pending, q=3 loaded on the swap edge.
    wait_slot(5);
    drive(1'b1, 4'hF, 4'd5, 2'b00);
    @(negedge clk);
    drive(1'b0, 4'h0, 4'h0, 2'd0);
    wait_slot(FRAME - 1);
    drive(1'b1, 4'hF, 4'd3, 2'b00);
    @(negedge clk);
    drive(1'b0, 4'h0, 4'h0, 2'd0);
    @(negedge clk);
    check("boundary_first_an", {28'd0, bus.an}, {28'd0, 4'b1110});
    check("boundary_first_q5", {25'd0, bus.seg}, {25'd0, 7'b0010010});
    wait_slot(0);
    @(negedge clk);
    check("boundary_next_q3", {25'd0, bus.seg}, {25'd0, 7'b0110000});

    // Two loads within one frame: only the last is shown.
    wait_slot(2);
    drive(1'b1, 4'hE, 4'd1, 2'b11);
    @(negedge clk);
    drive(1'b1, 4'hE, 4'd9, 2'b11);
    @(negedge clk);
    drive(1'b0, 4'h0, 4'h0, 2'd0);
    seen1 = 1'b0;
    seen9 = 1'b0;
    repeat (3 * FRAME) begin
      @(negedge clk);
      if (bus.an == 4'b1110 && bus.seg == 7'b1111001) seen1 = 1'b1;
      if (bus.an == 4'b1110 && bus.seg == 7'b0010000) seen9 = 1'b1;
    end
    check("two_loads_never_1", {31'd0, seen1}, 32'd0);
    check("two_loads_shows_9", {31'd0, seen9}, 32'd1);

    // Asynchronous reset mid-digit.
    wait_slot(6);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_an", {28'd0, bus.an}, {28'd0, 4'b1111});
    check("async_rst_seg", {25'd0, bus.seg}, {25'd0, 7'b1111111});
    check("async_rst_dp", {31'd0, bus.dp}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_an", {28'd0, bus.an}, {28'd0, 4'b1110});
    check("post_rst_dash", {25'd0, bus.seg}, {25'd0, 7'b0111111});
    repeat (2 * FRAME) @(negedge clk);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
